// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: word-addressed data RAM controller with programmable wait states and dErr on illegal accesses.
// Define DMEM_BYTE_WR_EN to add the dByteEn byte-lane write strobe port.
module data_mem_ctrl #(
    parameter logic [31:0] DATA_BASE   = 32'h10010000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] dAddress,
    input  logic [31:0] dWriteData,
`ifdef DMEM_BYTE_WR_EN
    input  logic [3:0]  dByteEn,
`endif
    output logic [31:0] dReadData,
    output logic        dReady,
    output logic        dErr
);
    localparam int AW = $clog2(DEPTH_WORDS);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, stateNext;
    logic [2:0] cnt, cntNext;
    logic capture, reqErr;
    logic [29:0] offWord;
    logic latWrite, latErr;
    logic [AW-1:0] latIdx;
    logic [31:0] latData;
    logic curWrite, curErr;
    logic [AW-1:0] curIdx;
    logic [31:0] mem [DEPTH_WORDS];
`ifdef DMEM_BYTE_WR_EN
    logic [3:0] latBe;
`endif
    // Word offset from the window base; a wrapped (below-base) address lands far above DEPTH_WORDS.
    assign offWord = dAddress[31:2] - DATA_BASE[31:2];
    assign reqErr = (dAddress[1:0] != 2'b00) | (dAddress < DATA_BASE) |
                    (offWord >= 30'(DEPTH_WORDS)) | (MemRead & MemWrite);
    // With zero latency the response is decided in the capture cycle, before the latches are loaded.
    assign curWrite = capture ? MemWrite : latWrite;
    assign curErr = capture ? reqErr : latErr;
    assign curIdx = capture ? offWord[AW-1:0] : latIdx;
    always_comb begin
        stateNext = state;
        cntNext = cnt;
        capture = 1'b0;
        unique case (state)
            IDLE: if (MemRead | MemWrite) begin
                capture = 1'b1;
                stateNext = (LATENCY == 0) ? RESP : WAIT;
                cntNext = 3'(LATENCY - 1);
            end
            WAIT: begin
                stateNext = (cnt == 3'd0) ? RESP : WAIT;
                cntNext = (cnt == 3'd0) ? cnt : cnt - 3'd1;
            end
            RESP: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt <= '0;
            dReady <= 1'b0;
            dErr <= 1'b0;
            dReadData <= '0;
            latWrite <= 1'b0;
            latErr <= 1'b0;
            latIdx <= '0;
            latData <= '0;
`ifdef DMEM_BYTE_WR_EN
            latBe <= '0;
`endif
        end else begin
            state <= stateNext;
            cnt <= cntNext;
            dReady <= stateNext == RESP;
            dErr <= (stateNext == RESP) && curErr;
            if (capture) begin
                latWrite <= MemWrite;
                latErr <= reqErr;
                latIdx <= offWord[AW-1:0];
                latData <= dWriteData;
`ifdef DMEM_BYTE_WR_EN
                latBe <= dByteEn;
`endif
            end
            if (stateNext == RESP)
                dReadData <= curErr ? '0 : curWrite ? dReadData : mem[curIdx];
        end
    end
    // RAM is never cleared; an access dropped by reset never reaches RESP so it never writes.
    always_ff @(posedge clk) begin
        if (state == RESP && latWrite && !latErr) begin
`ifdef DMEM_BYTE_WR_EN
            for (int i = 0; i < 4; i++)
                if (latBe[i]) mem[latIdx][8*i +: 8] <= latData[8*i +: 8];
`else
            mem[latIdx] <= latData;
`endif
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: vector table, reset and zero-latency corner sequences, and a randomized run
// checked against an array-based memory model.
module tb_data_mem_ctrl;
    localparam logic [31:0] BASE = 32'h10010000;
    localparam int DEPTH = 1024;
    localparam int LAT = 2;
    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] expData;
        logic        expErr;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic memRead = 1'b0, memWrite = 1'b0;
    logic [31:0] dAddress = '0, dWriteData = '0, dReadData;
    logic dReady, dErr;
`ifdef DMEM_BYTE_WR_EN
    logic [3:0] dByteEn = 4'hF;
`endif
    logic memReadZ = 1'b0, memWriteZ = 1'b0;
    logic [31:0] dAddressZ = '0, dWriteDataZ = '0, dReadDataZ;
    logic dReadyZ, dErrZ;
    int nVec = 0, nBad = 0;
    vec_t tbl [14];
    logic [31:0] refMem [DEPTH];
    logic [31:0] refData;

    always #5 clk = ~clk;

    data_mem_ctrl #(.DATA_BASE(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u0 (
        .clk(clk), .rst(rst), .MemRead(memRead), .MemWrite(memWrite),
        .dAddress(dAddress), .dWriteData(dWriteData),
`ifdef DMEM_BYTE_WR_EN
        .dByteEn(dByteEn),
`endif
        .dReadData(dReadData), .dReady(dReady), .dErr(dErr)
    );

    data_mem_ctrl #(.DATA_BASE(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(0)) u1 (
        .clk(clk), .rst(rst), .MemRead(memReadZ), .MemWrite(memWriteZ),
        .dAddress(dAddressZ), .dWriteData(dWriteDataZ),
`ifdef DMEM_BYTE_WR_EN
        .dByteEn(4'hF),
`endif
        .dReadData(dReadDataZ), .dReady(dReadyZ), .dErr(dErrZ)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One request held until dReady; inputs are scrambled mid-wait to show only latched values matter.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be, output logic [31:0] rdata, output logic err, output int lat);
        @(negedge clk);
        memRead = rd;
        memWrite = wr;
        dAddress = a;
        dWriteData = wd;
`ifdef DMEM_BYTE_WR_EN
        dByteEn = be;
`else
        if (be != 4'hF) $display("note: byte enables ignored in this build");
`endif
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1 && !dReady) begin
                dAddress = $urandom;
                dWriteData = $urandom;
            end
        end while (!dReady && lat < 20);
        rdata = dReadData;
        err = dErr;
        memRead = 1'b0;
        memWrite = 1'b0;
        @(posedge clk);
        #1;
        check("pulse width", 32'(dReady), 32'd0);
    endtask

    task automatic acc_chk(input string name, input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] be, input logic [31:0] expD, input logic expE);
        logic [31:0] d;
        logic e;
        int lat;
        access(rd, wr, a, wd, be, d, e, lat);
        check({name, " data"}, d, expD);
        check({name, " err"}, 32'(e), 32'(expE));
        check({name, " latency"}, 32'(lat), 32'(LAT + 1));
    endtask

    initial begin
        #500000;
        $display("FAIL global timeout");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 32'h10010004, 32'hDEADBEEF, 32'hAAAAAAAA, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 32'h10010004, 32'h0,        32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 32'h10010002, 32'h0,        32'h0,        1'b1};
        tbl[3]  = '{1'b1, 1'b0, 32'h1000FFFC, 32'h0,        32'h0,        1'b1};
        tbl[4]  = '{1'b1, 1'b0, 32'h10011000, 32'h0,        32'h0,        1'b1};
        tbl[5]  = '{1'b1, 1'b1, 32'h10010000, 32'h55555555, 32'h0,        1'b1};
        tbl[6]  = '{1'b1, 1'b0, 32'h10010000, 32'h0,        32'hAAAAAAAA, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 32'h10010FFC, 32'h12345678, 32'hAAAAAAAA, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 32'h10010FFC, 32'h0,        32'h12345678, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 32'h10011000, 32'hFFFFFFFF, 32'h0,        1'b1};
        tbl[10] = '{1'b1, 1'b0, 32'h10010000, 32'h0,        32'hAAAAAAAA, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 32'h10010006, 32'h99999999, 32'h0,        1'b1};
        tbl[12] = '{1'b1, 1'b0, 32'h10010004, 32'h0,        32'hDEADBEEF, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 32'h00000000, 32'h0,        32'h0,        1'b1};

        repeat (3) @(posedge clk);
        #1;
        check("reset data", dReadData, 32'h0);
        check("reset ready", 32'(dReady), 32'd0);
        check("reset err", 32'(dErr), 32'd0);
        check("reset z ready", 32'(dReadyZ), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        acc_chk("init write", 1'b0, 1'b1, BASE, 32'hAAAAAAAA, 4'hF, 32'h0, 1'b0);
        acc_chk("init read", 1'b1, 1'b0, BASE, 32'h0, 4'hF, 32'hAAAAAAAA, 1'b0);

        @(negedge clk);
        memWrite = 1'b1;
        dAddress = BASE;
        dWriteData = 32'h55555555;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midwait rst data", dReadData, 32'h0);
        check("midwait rst ready", 32'(dReady), 32'd0);
        check("midwait rst err", 32'(dErr), 32'd0);
        memWrite = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("held rst ready", 32'(dReady), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        acc_chk("post rst read", 1'b1, 1'b0, BASE, 32'h0, 4'hF, 32'hAAAAAAAA, 1'b0);

        foreach (tbl[i])
            acc_chk($sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, 4'hF,
                    tbl[i].expData, tbl[i].expErr);

`ifdef DMEM_BYTE_WR_EN
        acc_chk("be base", 1'b0, 1'b1, BASE + 8, 32'h11223344, 4'hF, 32'h0, 1'b0);
        acc_chk("be write", 1'b0, 1'b1, BASE + 8, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0);
        acc_chk("be read", 1'b1, 1'b0, BASE + 8, 32'h0, 4'hF, 32'h11BB33DD, 1'b0);
        acc_chk("be none", 1'b0, 1'b1, BASE + 8, 32'hFFFFFFFF, 4'b0000, 32'h11BB33DD, 1'b0);
        acc_chk("be reread", 1'b1, 1'b0, BASE + 8, 32'h0, 4'b0000, 32'h11BB33DD, 1'b0);
`endif

        // Zero-latency instance: single-cycle response and held-request repeat.
        @(negedge clk);
        memWriteZ = 1'b1;
        dAddressZ = BASE;
        dWriteDataZ = 32'h0BADF00D;
        @(posedge clk);
        #1;
        check("z write ready", 32'(dReadyZ), 32'd1);
        check("z write err", 32'(dErrZ), 32'd0);
        check("z write data", dReadDataZ, 32'h0);
        memWriteZ = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        memReadZ = 1'b1;
        @(posedge clk);
        #1;
        check("z read1 ready", 32'(dReadyZ), 32'd1);
        check("z read1 data", dReadDataZ, 32'h0BADF00D);
        @(posedge clk);
        #1;
        check("z gap ready", 32'(dReadyZ), 32'd0);
        @(posedge clk);
        #1;
        check("z read2 ready", 32'(dReadyZ), 32'd1);
        check("z read2 data", dReadDataZ, 32'h0BADF00D);
        memReadZ = 1'b0;
        @(posedge clk);
        #1;
        check("z idle ready", 32'(dReadyZ), 32'd0);

        // Randomized run: model is a plain word array plus the last returned read value.
        acc_chk("rnd sync", 1'b1, 1'b0, BASE - 4, 32'h0, 4'hF, 32'h0, 1'b1);
        refData = 32'h0;
        for (int k = 0; k < 12; k++) begin
            int w;
            logic [31:0] v;
            w = (k < 8) ? k : DEPTH - 1 - (k - 8);
            v = $urandom;
            acc_chk($sformatf("rnd init%0d", k), 1'b0, 1'b1, BASE + 32'(4 * w), v, 4'hF, refData, 1'b0);
            refMem[w] = v;
        end
        for (int n = 0; n < 300; n++) begin
            int k, op;
            logic rd, wr, legal;
            logic [31:0] a, wd, expD;
            logic [3:0] be;
            k = $urandom_range(0, 19);
            a = (k < 8) ? BASE + 32'(4 * k)
              : (k < 12) ? BASE + 32'(4 * (DEPTH - 1 - (k - 8)))
              : (k == 12) ? BASE + 32'(4 * DEPTH)
              : (k == 13) ? BASE - 32'd4
              : (k == 14) ? BASE + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(1, 3))
              : (k == 15) ? ($urandom | 32'd1)
              : BASE + 32'(4 * $urandom_range(0, 7));
            op = $urandom_range(0, 9);
            rd = (op < 5) || (op == 9);
            wr = (op >= 5);
            wd = $urandom;
`ifdef DMEM_BYTE_WR_EN
            be = 4'($urandom);
`else
            be = 4'hF;
`endif
            legal = (a % 4 == 0) && (a >= BASE) && ((a - BASE) < 32'(4 * DEPTH)) && !(rd && wr);
            if (!legal) expD = 32'h0;
            else if (wr) begin
                expD = refData;
                for (int b = 0; b < 4; b++)
                    if (be[b]) refMem[(a - BASE) / 4][8*b +: 8] = wd[8*b +: 8];
            end else expD = refMem[(a - BASE) / 4];
            acc_chk($sformatf("rnd%0d", n), rd, wr, a, wd, be, expD, !legal);
            refData = expD;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end
endmodule
